dm_access_arbiter: RTL and testbench

//  Sits in front of the single-port data memory and shares it between two requesters:
//  m0 = CPU load/store path, m1 = debug/DMA loader. Round-robin arbitration, one access/cycle.

---
 rtl/dm_access_arbiter.sv | 112 +++++++++++
 tb/tb_dm_access_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (m0) and the
// debug/DMA loader (m1). It also sequences a word-by-word memory clear after reset or on request.
module dm_access_arbiter #(
  parameter int ADDR_BITS      = 10,
  parameter int CLEAR_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_req,
  output logic        busy,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t                RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_BITS-1:0]  LAST_PTR    = ADDR_BITS'(CLEAR_WORDS - 1);
  localparam int                    PAD_BITS    = 30 - ADDR_BITS;

  state_t                state;
  state_t                stateNext;
  logic [ADDR_BITS-1:0]  clrPtr;
  logic [ADDR_BITS-1:0]  wordAddr;
  logic                  lastGnt;
  logic                  grant0;
  logic                  grant1;
  logic                  unusedBits;

  // Address bits outside the word index alias onto the same memory word.
  assign unusedBits = ^{m0_addr[31:ADDR_BITS+2], m0_addr[1:0],
                        m1_addr[31:ADDR_BITS+2], m1_addr[1:0]};

  always_comb begin
    stateNext = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    wordAddr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (reset) begin
      case (state)
        CLEAR: begin
          mem_we   = 1'b1;
          wordAddr = clrPtr;
          if (clrPtr == LAST_PTR) stateNext = RUN;
        end
        RUN: begin
          // On contention the port that did not win last time goes first.
          grant1 = m1_req && (!m0_req || !lastGnt);
          grant0 = m0_req && !grant1;
          if (grant1) begin
            wordAddr  = m1_addr[ADDR_BITS+1:2];
            mem_we    = m1_we;
            mem_wdata = m1_wdata;
          end else if (grant0) begin
            wordAddr  = m0_addr[ADDR_BITS+1:2];
            mem_we    = m0_we;
            mem_wdata = m0_wdata;
          end
          if (clear_req) stateNext = CLEAR;
        end
        default: stateNext = RESET_STATE;
      endcase
    end
  end

  assign mem_addr = {{PAD_BITS{1'b0}}, wordAddr, 2'b00};
  assign busy     = (state == CLEAR);
  assign m0_gnt   = grant0;
  assign m1_gnt   = grant1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RESET_STATE;
      clrPtr    <= '0;
      lastGnt   <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR) clrPtr <= clrPtr + 1'b1;
      else if (clear_req) clrPtr <= '0;
      if (grant0) lastGnt <= 1'b0;
      else if (grant1) lastGnt <= 1'b1;
      m0_rvalid <= grant0 && !m0_we;
      m1_rvalid <= grant1 && !m1_we;
      if (grant0 && !m0_we) m0_rdata <= mem_rdata;
      if (grant1 && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: a behavioural memory plus a reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_dm_access_arbiter;

  localparam int CW = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:CW-1];

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clock) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  dm_access_arbiter #(.ADDR_BITS(10), .CLEAR_WORDS(CW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the memory contents and what each cycle must show.
  bit          checkEn = 1'b0;
  bit          mBusy = 1'b1;
  int          mCnt = 0;
  int          mLast = 1;
  bit          mRv [2] = '{1'b0, 1'b0};
  logic [31:0] mRd [2] = '{32'h0, 32'h0};
  logic [31:0] refMem [CW];
  int          win, word;
  logic [31:0] rAddr, rWd;
  bit          rWe;

  always @(negedge clock) begin
    if (checkEn) begin
      check("busy", busy, mBusy);
      check("m0_rvalid", m0_rvalid, mRv[0]);
      check("m1_rvalid", m1_rvalid, mRv[1]);
      check("m0_rdata", m0_rdata, mRd[0]);
      check("m1_rdata", m1_rdata, mRd[1]);
      if (!reset) begin
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        mBusy = 1'b1; mCnt = 0; mLast = 1;
        mRv = '{1'b0, 1'b0}; mRd = '{32'h0, 32'h0};
      end else if (mBusy) begin
        check("clr_m0_gnt", m0_gnt, 0);
        check("clr_m1_gnt", m1_gnt, 0);
        check("clr_mem_we", mem_we, 1);
        check("clr_mem_addr", mem_addr, mCnt * 4);
        check("clr_mem_wdata", mem_wdata, 0);
        refMem[mCnt] = 32'h0;
        mCnt++;
        if (mCnt == CW) mBusy = 1'b0;
        mRv = '{1'b0, 1'b0};
      end else begin
        win = -1;
        if (m0_req && m1_req) win = 1 - mLast;
        else if (m0_req) win = 0;
        else if (m1_req) win = 1;
        check("m0_gnt", m0_gnt, win == 0);
        check("m1_gnt", m1_gnt, win == 1);
        mRv = '{1'b0, 1'b0};
        if (win < 0) begin
          check("idle_mem_we", mem_we, 0);
          check("idle_mem_addr", mem_addr, 0);
        end else begin
          rAddr = (win == 0) ? m0_addr : m1_addr;
          rWe   = (win == 0) ? m0_we : m1_we;
          rWd   = (win == 0) ? m0_wdata : m1_wdata;
          word  = int'((rAddr / 4) % CW);
          check("mem_we", mem_we, rWe);
          check("mem_addr", mem_addr, word * 4);
          if (rWe) begin
            check("mem_wdata", mem_wdata, rWd);
            refMem[word] = rWd;
          end else begin
            mRv[win] = 1'b1;
            mRd[win] = refMem[word];
          end
          mLast = win;
        end
        if (clear_req) begin mBusy = 1'b1; mCnt = 0; end
      end
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic setReq(input int p, input bit req, input bit we, input logic [31:0] a,
                        input logic [31:0] wd);
    if (p == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; end
  endtask

  // Returns at the negedge of the first cycle after the clear sequence.
  task automatic waitClear(input string tag);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      @(negedge clock);
      if (busy) begin
        if (n == 0) check({tag, "_clr_first_addr"}, mem_addr, 32'h0);
        if (n == CW - 1) check({tag, "_clr_last_addr"}, mem_addr, 32'hFFC);
        n++;
        cyc();
      end else done = 1'b1;
    end
    check({tag, "_clr_len"}, n, CW);
  endtask

  task automatic access(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    bit g = 1'b0;
    setReq(p, 1'b1, we, a, wd);
    for (int i = 0; i < 2000 && !g; i++) begin
      @(negedge clock);
      g = (p == 0) ? m0_gnt : m1_gnt;
      cyc();
    end
    check("access_gnt", g, 1);
    setReq(p, 1'b0, 1'b0, 32'h0, 32'h0);
    rd = 32'h0;
    if (!we) begin
      @(negedge clock);
      check("access_rvalid", (p == 0) ? m0_rvalid : m1_rvalid, 1);
      rd = (p == 0) ? m0_rdata : m1_rdata;
      cyc();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  logic [31:0] rd;

  initial begin
    // Reset, clear sequence with m0 waiting, first RUN cycle grants m0.
    reset = 1'b0;
    setReq(0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc();
    checkEn = 1'b1;
    cyc();
    reset = 1'b1;
    waitClear("t1");
    check("t1_first_gnt", m0_gnt, 1);
    cyc();
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write then read back on the very next cycle.
    access(0, 1'b1, 32'h40, 32'hDEADBEEF, rd);
    access(0, 1'b0, 32'h40, 32'h0, rd);
    check("t2_rdata", rd, 32'hDEADBEEF);

    // Contention from RUN entry alternates m0,m1,...
    reset = 1'b0;
    setReq(0, 1'b1, 1'b0, 32'h8, 32'h0);
    setReq(1, 1'b1, 1'b0, 32'hC, 32'h0);
    cyc();
    reset = 1'b1;
    waitClear("t3");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      check("t3_m0_gnt", m0_gnt, (i % 2) == 0);
      check("t3_m1_gnt", m1_gnt, (i % 2) == 1);
      cyc();
    end
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    setReq(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write coincident with clear_req commits, then the clear wipes it.
    access(1, 1'b1, 32'h84, 32'h11111111, rd);
    setReq(1, 1'b1, 1'b1, 32'h80, 32'h12345678);
    clear_req = 1'b1;
    @(negedge clock);
    check("t4_gnt", m1_gnt, 1);
    cyc();
    clear_req = 1'b0;
    setReq(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t4_mem_committed", mem[32], 32'h12345678);
    waitClear("t4");
    cyc();
    access(1, 1'b0, 32'h80, 32'h0, rd);
    check("t4_rdata_cleared", rd, 32'h0);

    // Upper address bits alias; byte offset bits ignored.
    access(0, 1'b1, 32'h1004, 32'hA5A5A5A5, rd);
    access(1, 1'b0, 32'h0004, 32'h0, rd);
    check("t5_alias", rd, 32'hA5A5A5A5);
    access(0, 1'b0, 32'h0006, 32'h0, rd);
    check("t5_lowbits", rd, 32'hA5A5A5A5);

    // Reset while a read is pending: no grant, no rvalid, clear restarts at word 0.
    setReq(0, 1'b1, 1'b0, 32'h40, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("t6_gnt", m0_gnt, 0);
    check("t6_mem_we", mem_we, 0);
    cyc();
    @(negedge clock);
    check("t6_rvalid", m0_rvalid, 0);
    check("t6_busy", busy, 1);
    cyc();
    reset = 1'b1;
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitClear("t6");
    cyc();

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      setReq(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 12),
             $urandom);
      setReq(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 13),
             $urandom);
      clear_req = ($urandom_range(0, 999) == 0);
      reset = ($urandom_range(0, 1499) != 0);
      cyc();
    end
    reset = 1'b1;
    clear_req = 1'b0;
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    setReq(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cyc();
    checkEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
